// File: rtl/rxb_ctl_if.sv
// rxb_ctl_if: BSP/TCL byte-capture side and CPU read-window side of the CAN receive buffer.
// 'release' is a reserved word, so the message-release pulse is carried as release_msg.
interface rxb_ctl_if #(
  parameter int unsigned AW = 6
);
  logic [7:0]    bsp_data;
  logic          bsp_ready;
  logic          tranceive;
  logic          frame_start;
  logic          frame_ok;
  logic          frame_err;
  logic [3:0]    rd_addr;
  logic          release_msg;
  logic [7:0]    rd_data;
  logic          rbs;
  logic          dos;
  logic          dos_clr;
  logic [AW-1:0] msg_cnt;

  modport slave (
    input  bsp_data, bsp_ready, tranceive, frame_start, frame_ok, frame_err,
    input  rd_addr, release_msg, dos_clr,
    output rd_data, rbs, dos, msg_cnt
  );

  modport master (
    output bsp_data, bsp_ready, tranceive, frame_start, frame_ok, frame_err,
    output rd_addr, release_msg, dos_clr,
    input  rd_data, rbs, dos, msg_cnt
  );
endinterface

// File: rtl/rxb_ctl.sv
// rxb_ctl: CAN receive buffer -- circular byte FIFO with frame commit/discard and a 10-byte
// CPU read window on the oldest message. Define RXB_OWN_FILTER_EN to drop self-transmitted frames.
module rxb_ctl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clock,
  rxb_ctl_if.slave bus
);
  localparam int unsigned PW        = AW + 1;
  localparam logic [AW:0] FULL_FILL = {1'b1, {AW{1'b0}}};

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   rd_ptr, wr_ptr, wr_tmp, tmp_nxt, msg_len;
  logic [3:0]    frame_cnt, cnt_nxt;
  logic [AW-1:0] msg_cnt_q, hdr_idx, win_idx;
  logic [4:0]    hdr_bits;
  logic          ready_q, ovr_frame, ovr_nxt, own_nxt, dos_q;
  logic          capture, cap_live, cap_wr, full, commit, set_dos, do_release;

  always_comb begin
    capture    = clock && bus.bsp_ready && !ready_q;
    // a byte landing together with frame_err belongs to the aborted frame
    cap_live   = capture && !bus.frame_err;
    full       = (wr_tmp - rd_ptr) == FULL_FILL;
    cap_wr     = cap_live && (frame_cnt < 4'd10) && !ovr_frame && !full;
    ovr_nxt    = ovr_frame || (cap_live && (frame_cnt < 4'd10) && full);
    tmp_nxt    = cap_wr ? wr_tmp + PW'(1) : wr_tmp;
    cnt_nxt    = cap_wr ? frame_cnt + 4'd1 : frame_cnt;
    commit     = bus.frame_ok && !bus.frame_err && !own_nxt && !ovr_nxt && (cnt_nxt >= 4'd2);
    set_dos    = bus.frame_ok && !bus.frame_err && !own_nxt && ovr_nxt;
    do_release = bus.release_msg && (msg_cnt_q != '0);
  end

  // Oldest message length from its header byte: RTR -> 2, else 2 + DLC clamped to 8.
  always_comb begin
    hdr_idx  = rd_ptr[AW-1:0] + AW'(1);
    hdr_bits = mem[hdr_idx][4:0];
    if (hdr_bits[4])
      msg_len = PW'(2);
    else if (hdr_bits[3:0] > 4'd8)
      msg_len = PW'(10);
    else
      msg_len = PW'(2) + PW'(hdr_bits[3:0]);
  end

`ifdef RXB_OWN_FILTER_EN
  logic own_frame;

  assign own_nxt = own_frame || (cap_live && bus.tranceive);

  always_ff @(posedge clk) begin
    if (reset || bus.frame_err)
      own_frame <= 1'b0;
    else if (bus.frame_ok)
      own_frame <= own_nxt;
    else if (bus.frame_start)
      own_frame <= 1'b0;
    else
      own_frame <= own_nxt;
  end
`else
  logic unused_tranceive;

  assign own_nxt          = 1'b0;
  assign unused_tranceive = bus.tranceive;
`endif

  always_ff @(posedge clk) begin
    if (cap_wr && !reset)
      mem[wr_tmp[AW-1:0]] <= bus.bsp_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      wr_tmp    <= '0;
      frame_cnt <= '0;
      ovr_frame <= 1'b0;
      ready_q   <= 1'b0;
      msg_cnt_q <= '0;
      dos_q     <= 1'b0;
    end else begin
      if (clock)
        ready_q <= bus.bsp_ready;
      if (do_release)
        rd_ptr <= rd_ptr + msg_len;
      msg_cnt_q <= msg_cnt_q + AW'(commit) - AW'(do_release);
      if (set_dos)
        dos_q <= 1'b1;
      else if (bus.dos_clr)
        dos_q <= 1'b0;

      if (bus.frame_err) begin
        wr_tmp    <= wr_ptr;
        frame_cnt <= '0;
      end else if (bus.frame_ok) begin
        frame_cnt <= cnt_nxt;
        ovr_frame <= ovr_nxt;
        if (commit) begin
          wr_ptr <= tmp_nxt;
          wr_tmp <= tmp_nxt;
        end else begin
          wr_tmp <= wr_ptr;
        end
      end else if (bus.frame_start) begin
        wr_tmp    <= wr_ptr;
        frame_cnt <= '0;
        ovr_frame <= 1'b0;
      end else begin
        wr_tmp    <= tmp_nxt;
        frame_cnt <= cnt_nxt;
        ovr_frame <= ovr_nxt;
      end
    end
  end

  always_comb begin
    win_idx     = rd_ptr[AW-1:0] + AW'(bus.rd_addr);
    bus.rd_data = ((msg_cnt_q != '0) && (bus.rd_addr <= 4'd9)) ? mem[win_idx] : 8'h00;
    bus.rbs     = (msg_cnt_q != '0);
    bus.dos     = dos_q;
    bus.msg_cnt = msg_cnt_q;
  end

endmodule
